// File: rtl/codec_seq_pkg.sv
// ----------------------------------------------------------------------------
// codec_seq_pkg
// Shared definitions for the codec bring-up sequencer:
//   state_t      - sequencer state encodings (also driven on the state port)
//   RATE_*       - rate_sel codes; bit0 drives PLL FS1, bit1 drives PLL FS2
//   cnt_width()  - width of a saturating counter that must hold 0..limit
// ----------------------------------------------------------------------------
package codec_seq_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PLL_CFG  = 3'd1,
      PLL_WAIT = 3'd2,
      ADC_CFG  = 3'd3,
      SYNC     = 3'd4,
      RUN      = 3'd5,
      FAULT    = 3'd6
   } state_t;

   localparam logic [1:0] RATE_48K  = 2'b00;
   localparam logic [1:0] RATE_44K1 = 2'b01;
   localparam logic [1:0] RATE_96K  = 2'b10;
   localparam logic [1:0] RATE_32K  = 2'b11;

   function automatic int cnt_width(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/codec_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// codec_seq_ctrl_if
// Bundles the sequencer's control inputs, codec pins and status.
//   ctrl  modport - the sequencer side (drives pins and status)
//   codec modport - the host/codec side (drives en, rate_sel, lrck)
// ----------------------------------------------------------------------------
interface codec_seq_ctrl_if;

   logic       en;
   logic [1:0] rate_sel;
   logic       lrck;
   logic       pll_csel;
   logic       pll_fs1;
   logic       pll_fs2;
   logic       pll_sr;
   logic       adc_fmt;
   logic       adc_md1;
   logic       adc_md2;
   logic       dac_nmute;
   logic       ready;
   logic       fault;
   logic [2:0] state;

   modport ctrl (
      input  en, rate_sel, lrck,
      output pll_csel, pll_fs1, pll_fs2, pll_sr,
      output adc_fmt, adc_md1, adc_md2, dac_nmute,
      output ready, fault, state
   );

   modport codec (
      output en, rate_sel, lrck,
      input  pll_csel, pll_fs1, pll_fs2, pll_sr,
      input  adc_fmt, adc_md1, adc_md2, dac_nmute,
      input  ready, fault, state
   );

endinterface

// File: rtl/lrck_edge_sync.sv
// ----------------------------------------------------------------------------
// lrck_edge_sync
// Brings the asynchronous ADC LRCK into the clk domain through two flops and
// emits a registered one-cycle pulse on each rising edge of the synced value.
//   clk, rst - system clock, synchronous active-high reset
//   lrck     - raw LRCK from the ADC (asynchronous)
//   rise     - one-cycle pulse per LRCK rising edge
// ----------------------------------------------------------------------------
module lrck_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic lrck,
   output logic rise
);

   logic sync1_reg;
   logic sync2_reg;
   logic prev_reg;
   logic rise_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         prev_reg  <= 1'b0;
         rise_reg  <= 1'b0;
      end else begin
         sync1_reg <= lrck;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
         rise_reg  <= sync2_reg & ~prev_reg;
      end
   end

   assign rise = rise_reg;

endmodule

// File: rtl/codec_seq_ctrl.sv
// ----------------------------------------------------------------------------
// codec_seq_ctrl
// Power-up sequencer for a PLL + ADC + DAC codec chain: configure the PLL,
// wait for it to settle, configure the ADC, wait for LRCK_FRAMES LRCK frames,
// then unmute the DAC. A rate_sel change while syncing/running re-runs the
// PLL setup; en=0 returns to IDLE with every pin low.
//   clk, rst         - 50 MHz clock, synchronous active-high reset
//   en, rate_sel     - bring-up request and sample-rate select
//   i_adc_lrck       - ADC LRCK (asynchronous)
//   o_pll_*          - PLL configuration pins
//   o_adc_*          - ADC mode pins
//   o_dac_nmute      - 1 = DAC unmuted (RUN only)
//   ready/fault/state- status
// Build option: define CODEC_SEQ_WDOG_EN to enable the LRCK watchdog that
// moves SYNC/RUN to FAULT when LRCK stops; otherwise fault is tied low and
// SYNC waits indefinitely.
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module codec_seq_ctrl
   import codec_seq_pkg::*;
#(
   parameter int         PLL_SETTLE_CYC = 50000,
   parameter int         LRCK_FRAMES    = 16,
   parameter int         WDOG_CYC       = 2048,
   parameter logic       ADC_FMT        = 1'b0,
   parameter logic [1:0] ADC_MD         = 2'b00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] rate_sel,
   input  logic       i_adc_lrck,
   output logic       o_pll_csel,
   output logic       o_pll_fs1,
   output logic       o_pll_fs2,
   output logic       o_pll_sr,
   output logic       o_adc_fmt,
   output logic       o_adc_md1,
   output logic       o_adc_md2,
   output logic       o_dac_nmute,
   output logic       ready,
   output logic       fault,
   output logic [2:0] state
);

   localparam int PLL_W = cnt_width(PLL_SETTLE_CYC);
   localparam int FRM_W = cnt_width(LRCK_FRAMES);

   localparam logic [PLL_W-1:0] PLL_LAST = PLL_W'(PLL_SETTLE_CYC - 1);
   localparam logic [PLL_W-1:0] PLL_MAX  = PLL_W'(PLL_SETTLE_CYC);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(LRCK_FRAMES - 1);
   localparam logic [FRM_W-1:0] FRM_MAX  = FRM_W'(LRCK_FRAMES);

   state_t           state_reg;
   logic [1:0]       rate_q_reg;
   logic [PLL_W-1:0] pll_cnt_reg;
   logic [FRM_W-1:0] frm_cnt_reg;
   logic             csel_reg, fs1_reg, fs2_reg, sr_reg;
   logic             fmt_reg, md1_reg, md2_reg;
   logic             nmute_reg, ready_reg;
   logic             rise;

   lrck_edge_sync u_lrck_edge_sync (
      .clk  (clk),
      .rst  (rst),
      .lrck (i_adc_lrck),
      .rise (rise)
   );

`ifdef CODEC_SEQ_WDOG_EN
   localparam int WDOG_W = cnt_width(WDOG_CYC);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);
   localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_CYC);

   logic [WDOG_W-1:0] wdog_cnt_reg;
   logic              fault_reg;
   logic              wdog_hit;

   // Counts clk cycles since the last LRCK edge; only runs while waiting on
   // or consuming LRCK, and is restarted as the ADC is configured.
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt_reg <= '0;
      end else if (state_reg == ADC_CFG || rise) begin
         wdog_cnt_reg <= '0;
      end else if ((state_reg == SYNC || state_reg == RUN) &&
                   wdog_cnt_reg != WDOG_MAX) begin
         wdog_cnt_reg <= wdog_cnt_reg + WDOG_W'(1);
      end
   end

   assign wdog_hit = (wdog_cnt_reg == WDOG_LAST);
   assign fault    = fault_reg;
`else
   assign fault = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         rate_q_reg  <= 2'b00;
         pll_cnt_reg <= '0;
         frm_cnt_reg <= '0;
         csel_reg    <= 1'b0;
         fs1_reg     <= 1'b0;
         fs2_reg     <= 1'b0;
         sr_reg      <= 1'b0;
         fmt_reg     <= 1'b0;
         md1_reg     <= 1'b0;
         md2_reg     <= 1'b0;
         nmute_reg   <= 1'b0;
         ready_reg   <= 1'b0;
`ifdef CODEC_SEQ_WDOG_EN
         fault_reg   <= 1'b0;
`endif
      end else if (!en && state_reg != IDLE) begin
         // Shutdown beats everything, including a pending FAULT.
         state_reg   <= IDLE;
         csel_reg    <= 1'b0;
         fs1_reg     <= 1'b0;
         fs2_reg     <= 1'b0;
         sr_reg      <= 1'b0;
         fmt_reg     <= 1'b0;
         md1_reg     <= 1'b0;
         md2_reg     <= 1'b0;
         nmute_reg   <= 1'b0;
         ready_reg   <= 1'b0;
`ifdef CODEC_SEQ_WDOG_EN
         fault_reg   <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (en) state_reg <= PLL_CFG;
            end
            PLL_CFG: begin
               // fs pins take rate_sel directly: identical to the value
               // latched into rate_q on this same edge.
               rate_q_reg  <= rate_sel;
               csel_reg    <= 1'b1;
               fs1_reg     <= rate_sel[0];
               fs2_reg     <= rate_sel[1];
               sr_reg      <= 1'b0;
               pll_cnt_reg <= '0;
               state_reg   <= PLL_WAIT;
            end
            PLL_WAIT: begin
               if (pll_cnt_reg == PLL_LAST) begin
                  state_reg <= ADC_CFG;
               end else if (pll_cnt_reg != PLL_MAX) begin
                  pll_cnt_reg <= pll_cnt_reg + PLL_W'(1);
               end
            end
            ADC_CFG: begin
               fmt_reg     <= ADC_FMT;
               md1_reg     <= ADC_MD[0];
               md2_reg     <= ADC_MD[1];
               frm_cnt_reg <= '0;
               state_reg   <= SYNC;
            end
            SYNC, RUN: begin
               if (rate_sel != rate_q_reg) begin
                  state_reg <= PLL_CFG;
                  nmute_reg <= 1'b0;
                  ready_reg <= 1'b0;
               end else if (state_reg == SYNC && rise &&
                            frm_cnt_reg == FRM_LAST) begin
                  state_reg <= RUN;
                  nmute_reg <= 1'b1;
                  ready_reg <= 1'b1;
               end
`ifdef CODEC_SEQ_WDOG_EN
               // An edge arriving on the expiry cycle restarts the watchdog
               // instead of faulting.
               else if (wdog_hit && !rise) begin
                  state_reg <= FAULT;
                  nmute_reg <= 1'b0;
                  ready_reg <= 1'b0;
                  fault_reg <= 1'b1;
               end
`endif
               else if (state_reg == SYNC && rise && frm_cnt_reg != FRM_MAX) begin
                  frm_cnt_reg <= frm_cnt_reg + FRM_W'(1);
               end
            end
            FAULT: begin
               // Pins held; only en=0 (handled above) leaves this state.
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign o_pll_csel  = csel_reg;
   assign o_pll_fs1   = fs1_reg;
   assign o_pll_fs2   = fs2_reg;
   assign o_pll_sr    = sr_reg;
   assign o_adc_fmt   = fmt_reg;
   assign o_adc_md1   = md1_reg;
   assign o_adc_md2   = md2_reg;
   assign o_dac_nmute = nmute_reg;
   assign ready       = ready_reg;
   assign state       = state_reg;

endmodule
